// File: rtl/dna_pattern_scanner_if.sv
// rtl/dna_pattern_scanner_if.sv - word/pattern/result bundle for the DNA pattern scanner
// master drives words and pattern control; slave (the scanner) returns handshake, match and count.
interface dna_pattern_scanner_if #(
    parameter int WORD_SYMS = 8,
    parameter int PAT_LEN   = 4,
    parameter int CNT_W     = 8
);
    localparam int POS_W = (WORD_SYMS > 1) ? $clog2(WORD_SYMS) : 1;

    logic                   word_valid;
    logic [2*WORD_SYMS-1:0] word_in;
    logic                   word_ready;
    logic                   pat_load;
    logic [2*PAT_LEN-1:0]   pattern_in;
    logic                   overlap_en;
    logic                   busy;
    logic                   match;
    logic [POS_W-1:0]       match_pos;
    logic                   done;
    logic [CNT_W-1:0]       match_count;

    modport master (
        output word_valid, word_in, pat_load, pattern_in, overlap_en,
        input  word_ready, busy, match, match_pos, done, match_count
    );

    modport slave (
        input  word_valid, word_in, pat_load, pattern_in, overlap_en,
        output word_ready, busy, match, match_pos, done, match_count
    );
endinterface

// File: rtl/dna_pattern_scanner.sv
// rtl/dna_pattern_scanner.sv - streaming 2-bit nucleotide pattern matcher, one symbol per clock
// Define DNA_SCAN_COUNT_EN to build the saturating match counter; otherwise match_count is tied to 0.
module dna_pattern_scanner #(
    parameter int WORD_SYMS = 8,
    parameter int PAT_LEN   = 4,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    dna_pattern_scanner_if.slave    bus
);
    localparam int POS_W  = (WORD_SYMS > 1) ? $clog2(WORD_SYMS) : 1;
    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam int WW     = 2 * WORD_SYMS;
    localparam int PW     = 2 * PAT_LEN;

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t            state_q, state_d;
    logic [WW-1:0]     word_q, word_d;
    logic [POS_W-1:0]  idx_q, idx_d;
    logic [PW-1:0]     window_q, window_d;
    logic [PW-1:0]     pattern_q, pattern_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              match_q, match_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              done_q, done_d;

    logic              last_sym;
    logic              load_ok;
    logic              accept;
    logic              hit;
    logic [1:0]        sym;
    logic [PW-1:0]     window_shift;
    logic [FILL_W-1:0] fill_shift;

    // The word register shifts left each scan, so the next symbol is always the top pair.
    assign sym          = word_q[WW-1 -: 2];
    assign window_shift = (window_q << 2) | PW'(sym);
    assign fill_shift   = (fill_q == FILL_W'(PAT_LEN)) ? fill_q : fill_q + FILL_W'(1);
    assign hit          = (fill_shift == FILL_W'(PAT_LEN)) && (window_shift == pattern_q);

    assign last_sym       = (state_q == S_SCAN) && (idx_q == POS_W'(WORD_SYMS - 1));
    assign load_ok        = (state_q == S_IDLE) && bus.pat_load;
    assign bus.word_ready = ((state_q == S_IDLE) && !bus.pat_load) || last_sym;
    assign accept         = bus.word_valid && bus.word_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            idx_q     <= '0;
            window_q  <= '0;
            pattern_q <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            pos_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            idx_q     <= idx_d;
            window_q  <= window_d;
            pattern_q <= pattern_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            pos_q     <= pos_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        idx_d     = idx_q;
        window_d  = window_q;
        pattern_d = pattern_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
        pos_d     = pos_q;
        done_d    = 1'b0;

        if (state_q == S_SCAN) begin
            window_d = window_shift;
            fill_d   = (hit && !bus.overlap_en) ? '0 : fill_shift;
            word_d   = word_q << 2;
            idx_d    = idx_q + POS_W'(1);
            match_d  = hit;
            if (hit) begin
                pos_d = idx_q;
            end
            if (last_sym) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end

        if (load_ok) begin
            pattern_d = bus.pattern_in;
            fill_d    = '0;
        end

        // A word accepted on the last-symbol edge restarts the scan with no idle cycle.
        if (accept) begin
            word_d  = bus.word_in;
            idx_d   = '0;
            state_d = S_SCAN;
        end
    end

    assign bus.busy      = (state_q == S_SCAN);
    assign bus.match     = match_q;
    assign bus.match_pos = pos_q;
    assign bus.done      = done_q;

`ifdef DNA_SCAN_COUNT_EN
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (match_d && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.match_count = count_q;
`else
    assign bus.match_count = '0;
`endif
endmodule

// File: tb/tb_dna_pattern_scanner.sv
// tb/tb_dna_pattern_scanner.sv - directed table-driven bench for dna_pattern_scanner
// Main instance uses default sizes; a second instance with CNT_W=2 exercises counter saturation.
module tb_dna_pattern_scanner;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dna_pattern_scanner_if #(.WORD_SYMS(8), .PAT_LEN(4), .CNT_W(8)) ifa ();
    dna_pattern_scanner_if #(.WORD_SYMS(8), .PAT_LEN(4), .CNT_W(2)) ifb ();

    dna_pattern_scanner #(.WORD_SYMS(8), .PAT_LEN(4), .CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    dna_pattern_scanner #(.WORD_SYMS(8), .PAT_LEN(4), .CNT_W(2)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    typedef struct {
        logic        do_load;
        logic [7:0]  pat;
        logic        ov;
        logic [15:0] w0;
        logic [15:0] w1;
        int          nw;
        logic [7:0]  m0;
        logic [7:0]  m1;
        int          cnt;
    } vec_t;

    localparam int NV = 10;
    vec_t vt [NV];

    int     n_checks = 0;
    int     n_errors = 0;
    longint cyc_cnt = 0;
    int     mon_done_cnt = 0;
    longint last_done_cyc = 0;
    int     hit_log [$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Each hit is logged as (absolute word index * 16 + position).
    always @(negedge clk) begin
        if (ifa.match === 1'b1) hit_log.push_back(mon_done_cnt * 16 + int'(ifa.match_pos));
        if (ifa.done === 1'b1) begin
            mon_done_cnt  <= mon_done_cnt + 1;
            last_done_cyc <= cyc_cnt;
        end
    end

    function automatic int exp_cnt(input int c);
`ifdef DNA_SCAN_COUNT_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ifa.word_valid = 1'b0; ifa.word_in = '0; ifa.pat_load = 1'b0; ifa.pattern_in = '0; ifa.overlap_en = 1'b0;
        ifb.word_valid = 1'b0; ifb.word_in = '0; ifb.pat_load = 1'b0; ifb.pattern_in = '0; ifb.overlap_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_pat(input logic [7:0] p);
        @(negedge clk);
        ifa.pat_load = 1'b1;
        ifa.pattern_in = p;
        @(posedge clk);
        @(negedge clk);
        ifa.pat_load = 1'b0;
    endtask

    task automatic send_words(input logic [15:0] w0, input logic [15:0] w1, input int nw, output longint acc_cyc);
        int   acc = 0;
        int   guard = 0;
        logic r;
        acc_cyc = 0;
        @(negedge clk);
        ifa.word_valid = 1'b1;
        ifa.word_in = w0;
        while (acc < nw && guard < 50) begin
            #1 r = ifa.word_ready;
            @(posedge clk);
            #1;
            guard++;
            if (r === 1'b1) begin
                if (acc == 0) acc_cyc = cyc_cnt;
                acc++;
            end
            @(negedge clk);
            if (acc >= nw) ifa.word_valid = 1'b0;
            else ifa.word_in = (acc == 0) ? w0 : w1;
        end
        if (acc < nw) check("accept_timeout", acc, nw);
    endtask

    task automatic wait_done(input int base, input int n);
        int g = 0;
        #2;
        while ((mon_done_cnt - base) < n && g < 200) begin
            @(negedge clk);
            #2;
            g++;
        end
        if ((mon_done_cnt - base) < n) check("done_timeout", mon_done_cnt - base, n);
    endtask

    task automatic get_masks(input int bl, input int bd, output logic [7:0] m0, output logic [7:0] m1);
        m0 = '0;
        m1 = '0;
        for (int i = bl; i < hit_log.size(); i++) begin
            int w;
            int p;
            w = hit_log[i] / 16 - bd;
            p = hit_log[i] % 16;
            if (w == 0) m0[p[2:0]] = 1'b1;
            else if (w == 1) m1[p[2:0]] = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t        v;
        int          bl;
        int          bd;
        longint      acc;
        logic [7:0]  m0;
        logic [7:0]  m1;
        logic        r;
        int          ga;

        // do_load, pat, ov, w0, w1, nw, mask0, mask1, count
        vt[0] = '{1'b0, 8'h00, 1'b1, 16'h0000, 16'h0000, 1, 8'hF8, 8'h00, 5};
        vt[1] = '{1'b1, 8'h8D, 1'b1, 16'h8D8D, 16'h0000, 1, 8'h88, 8'h00, 2};
        vt[2] = '{1'b1, 8'h00, 1'b1, 16'h0000, 16'h0000, 1, 8'hF8, 8'h00, 5};
        vt[3] = '{1'b1, 8'h00, 1'b0, 16'h0000, 16'h0000, 1, 8'h88, 8'h00, 2};
        vt[4] = '{1'b1, 8'h8D, 1'b1, 16'h0008, 16'hD000, 2, 8'h00, 8'h02, 1};
        vt[5] = '{1'b1, 8'h00, 1'b0, 16'h0000, 16'h0000, 2, 8'h88, 8'h88, 4};
        vt[6] = '{1'b1, 8'h00, 1'b1, 16'h0000, 16'h0000, 2, 8'hF8, 8'hFF, 13};
        vt[7] = '{1'b1, 8'h8D, 1'b1, 16'hFFFF, 16'h0000, 1, 8'h00, 8'h00, 0};
        vt[8] = '{1'b1, 8'h1B, 1'b0, 16'h1B1B, 16'h0000, 1, 8'h88, 8'h00, 2};
        vt[9] = '{1'b1, 8'h99, 1'b1, 16'h9999, 16'h0000, 1, 8'hA8, 8'h00, 3};

        rst = 1'b1;
        ifa.word_valid = 1'b0; ifa.word_in = '0; ifa.pat_load = 1'b0; ifa.pattern_in = '0; ifa.overlap_en = 1'b0;
        ifb.word_valid = 1'b0; ifb.word_in = '0; ifb.pat_load = 1'b0; ifb.pattern_in = '0; ifb.overlap_en = 1'b0;

        do_reset();
        #1;
        check("rst_busy", ifa.busy, 0);
        check("rst_ready", ifa.word_ready, 1);
        check("rst_match", ifa.match, 0);
        check("rst_done", ifa.done, 0);
        check("rst_pos", ifa.match_pos, 0);
        check("rst_count", ifa.match_count, 0);

        for (int i = 0; i < NV; i++) begin
            v = vt[i];
            do_reset();
            if (v.do_load) load_pat(v.pat);
            ifa.overlap_en = v.ov;
            bl = hit_log.size();
            bd = mon_done_cnt;
            send_words(v.w0, v.w1, v.nw, acc);
            wait_done(bd, v.nw);
            repeat (3) @(negedge clk);
            #2;
            get_masks(bl, bd, m0, m1);
            check($sformatf("v%0d_mask0", i), m0, v.m0);
            check($sformatf("v%0d_mask1", i), m1, v.m1);
            check($sformatf("v%0d_count", i), ifa.match_count, exp_cnt(v.cnt));
            check($sformatf("v%0d_latency", i), last_done_cyc - acc, 8 * v.nw);
            check($sformatf("v%0d_dones", i), mon_done_cnt - bd, v.nw);
            check($sformatf("v%0d_idle", i), ifa.busy, 0);
        end

        // Reset mid-scan: the word in flight must vanish without a match or done.
        do_reset();
        load_pat(8'h8D);
        ifa.overlap_en = 1'b1;
        bl = hit_log.size();
        bd = mon_done_cnt;
        @(negedge clk);
        ifa.word_valid = 1'b1;
        ifa.word_in = 16'h8D8D;
        #1 r = ifa.word_ready;
        check("midrst_accept", r, 1);
        @(posedge clk);
        @(negedge clk);
        ifa.word_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", ifa.busy, 0);
        check("midrst_ready", ifa.word_ready, 1);
        repeat (12) @(negedge clk);
        #2;
        check("midrst_hits", hit_log.size() - bl, 0);
        check("midrst_dones", mon_done_cnt - bd, 0);
        check("midrst_count", ifa.match_count, 0);

        // pat_load while busy is ignored; pat_load with word_valid when idle wins first.
        do_reset();
        load_pat(8'h8D);
        ifa.overlap_en = 1'b1;
        bl = hit_log.size();
        bd = mon_done_cnt;
        @(negedge clk);
        ifa.word_valid = 1'b1;
        ifa.word_in = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        ifa.word_valid = 1'b0;
        #1;
        check("busyload_busy", ifa.busy, 1);
        ifa.pat_load = 1'b1;
        ifa.pattern_in = 8'h00;
        @(posedge clk);
        @(negedge clk);
        ifa.pat_load = 1'b0;
        wait_done(bd, 1);
        send_words(16'h8D8D, 16'h0000, 1, acc);
        wait_done(bd, 2);
        #2;
        get_masks(bl, bd, m0, m1);
        check("busyload_w0", m0, 8'h00);
        check("busyload_w1", m1, 8'h88);

        bl = hit_log.size();
        bd = mon_done_cnt;
        @(negedge clk);
        ifa.pat_load = 1'b1;
        ifa.pattern_in = 8'h1B;
        ifa.word_valid = 1'b1;
        ifa.word_in = 16'h1B1B;
        #1;
        check("idleload_ready_low", ifa.word_ready, 0);
        @(posedge clk);
        @(negedge clk);
        ifa.pat_load = 1'b0;
        #1;
        check("idleload_ready_high", ifa.word_ready, 1);
        @(posedge clk);
        @(negedge clk);
        ifa.word_valid = 1'b0;
        #1;
        check("idleload_busy", ifa.busy, 1);
        wait_done(bd, 1);
        repeat (3) @(negedge clk);
        #2;
        get_masks(bl, bd, m0, m1);
        check("idleload_mask", m0, 8'h88);
        check("hold_match", ifa.match, 0);
        check("hold_pos", ifa.match_pos, 7);

        // Counter saturation on the CNT_W=2 instance.
        do_reset();
        @(negedge clk);
        ifb.overlap_en = 1'b1;
        ifb.word_valid = 1'b1;
        ifb.word_in = 16'h0000;
        ga = 0;
        for (int g = 0; g < 40 && ga < 2; g++) begin
            #1 r = ifb.word_ready;
            @(posedge clk);
            if (r === 1'b1) ga++;
            @(negedge clk);
            if (ga >= 2) ifb.word_valid = 1'b0;
        end
        check("sat_accepts", ga, 2);
        repeat (20) @(negedge clk);
        #1;
        check("sat_count", ifb.match_count, exp_cnt(3));
        check("sat_idle", ifb.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dna_pattern_scanner.md
DNA_PATTERN_SCANNER -- requirements
Module: dna_pattern_scanner

Interface
REQ-001 SHALL have parameter WORD_SYMS, default 8: nucleotide symbols per input word (2 bits each; A=00, C=01, G=10, T=11).
REQ-002 SHALL have parameter PAT_LEN, default 4: pattern length in symbols; legal range 1..WORD_SYMS.
REQ-003 SHALL have parameter CNT_W, default 8: match counter width.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port word_valid  in  1  input word offered.
REQ-007 SHALL have port word_in  in  2*WORD_SYMS  symbol word; MSB pair is symbol 0, scanned first.
REQ-008 SHALL have port word_ready  out  1  scanner can accept a word this cycle.
REQ-009 SHALL have port pat_load  in  1  load pattern_in into pattern register.
REQ-010 SHALL have port pattern_in  in  2*PAT_LEN  pattern; MSB pair is oldest symbol.
REQ-011 SHALL have port overlap_en  in  1  1 = overlapping matches, 0 = non-overlapping.
REQ-012 SHALL have port busy  out  1  word scan in progress.
REQ-013 SHALL have port match  out  1  one-cycle pulse per detected pattern.
REQ-014 SHALL have port match_pos  out  clog2(WORD_SYMS) (min 1)  index of completing symbol within current word, valid with match.
REQ-015 SHALL have port done  out  1  one-cycle pulse when last symbol of a word is scanned.
REQ-016 SHALL have port match_count  out  CNT_W  saturating total match count.

Function
REQ-017 SHALL accept a word at a rising edge where word_valid && word_ready; acceptance edge is E.
REQ-018 SHALL shift symbol k (k=0..WORD_SYMS-1) into a PAT_LEN-deep window at edge E+1+k, one symbol per cycle, no bubbles.
REQ-019 SHALL keep a fill counter (0..PAT_LEN, saturating); a match requires fill == PAT_LEN after the shift and window == pattern.
REQ-020 SHALL register match, match_pos and match_count at the same edge that shifts in the completing symbol; match high exactly the following cycle.
REQ-021 SHALL, with overlap_en=1, retain window and fill after a match; with overlap_en=0, set fill to 0 at the match edge.
REQ-022 SHALL carry window and fill across word boundaries, so patterns spanning two consecutive words are detected.
REQ-023 SHALL drive word_ready = !busy || (scan of symbol WORD_SYMS-1 occurs at the next edge), allowing gapless back-to-back words.
REQ-024 SHALL pulse done in the cycle after the edge that scans symbol WORD_SYMS-1; busy falls at that edge unless a new word is accepted at it.
REQ-025 SHALL honour pat_load only when busy=0; pat_load has priority over word acceptance (word_ready low that cycle); loading clears fill to 0.
REQ-026 SHALL ignore pat_load while busy; pattern register unchanged.
REQ-027 SHALL saturate match_count at 2^CNT_W-1.
REQ-028 SHALL hold match_pos at its last value when match is low.

Reset
REQ-029 SHALL on rst clear: word_ready=1 next cycle, busy=0, match=0, done=0, match_pos=0, match_count=0, window=0, fill=0, pattern=0 (all A).
REQ-030 SHALL let rst override all inputs, including mid-scan: current word discarded, no match/done for it.

Configuration
REQ-031 SHALL, with macro DNA_SCAN_COUNT_EN defined, implement match_count per REQ-016/020/027.
REQ-032 SHALL, without DNA_SCAN_COUNT_EN, drive match_count constant 0 and omit the counter logic; all other behaviour unchanged.

Verification (WORD_SYMS=8, PAT_LEN=4, CNT_W=8 unless stated)
REQ-033 SHALL cover: pattern 8'h8D (GATC), overlap_en=1, word 16'h8D8D -> match at pos 3 and 7, done with second match, count=2.
REQ-034 SHALL cover: pattern 8'h00 (AAAA), word 16'h0000 -> overlap_en=1: matches pos 3,4,5,6,7 (count 5); overlap_en=0: pos 3,7 (count 2).
REQ-035 SHALL cover: pattern 8'h8D, back-to-back words 16'h0008 then 16'hD000 with word_valid held -> no idle cycle between scans, single match at pos 1 of second word.
REQ-036 SHALL cover: rst asserted at E+3 during scan of 16'h8D8D -> no match, done or count change; busy=0, word_ready=1 after reset.
REQ-037 SHALL cover: pat_load while busy ignored; pat_load and word_valid together when idle -> pattern loaded, word accepted next cycle.
REQ-038 SHALL cover: CNT_W=2, pattern 8'h00, overlap_en=1, two words 16'h0000 -> count reaches 3 and holds; build without DNA_SCAN_COUNT_EN -> count stays 0.
